// File: rtl/decoder_3_8_strobe.sv
// Registered 3-to-8 decoder: each accepted code becomes one fixed-length
// one-hot strobe on Y, followed by a minimum idle gap.
module decoder_3_8_strobe #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic [2:0] A,
    input  logic       A_valid,
    output logic       A_ready,
    output logic [7:0] Y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       accept;

    assign A_ready = En & (state_q == IDLE) & ~rst;
    assign accept  = A_valid & A_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PULSE;
                    y_d     = 8'd1 << A;
                    cnt_d   = PULSE_LOAD;
                    busy_d  = 1'b1;
                end
            end
            PULSE: begin
                if (!En) begin
                    // Abort: drop the strobe silently, no completion pulse.
                    state_d = IDLE;
                    y_d     = 8'd0;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    y_d    = 8'd0;
                    done_d = 1'b1;
                    if (GAP_LEN > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            GAP: begin
                if (!En) begin
                    state_d = IDLE;
                    y_d     = 8'd0;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = 8'd0;
                cnt_d   = 8'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            y_q     <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_3_8_strobe.sv
// Directed bench for decoder_3_8_strobe: default timing instance plus a
// PULSE_LEN=1 / GAP_LEN=0 instance for the back-to-back corner.
module tb_decoder_3_8_strobe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [2:0] a = 3'd0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] y;
    logic       busy;
    logic       done;

    logic       s_en = 1'b1;
    logic [2:0] s_a = 3'd0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_y;
    logic       s_busy;
    logic       s_done;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    decoder_3_8_strobe dut (
        .clk(clk), .rst(rst), .En(en), .A(a), .A_valid(a_valid),
        .A_ready(a_ready), .Y(y), .busy(busy), .done(done)
    );

    decoder_3_8_strobe #(.PULSE_LEN(1), .GAP_LEN(0)) dut_s (
        .clk(clk), .rst(rst), .En(s_en), .A(s_a), .A_valid(s_valid),
        .A_ready(s_ready), .Y(s_y), .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks_total++;
        if (obs == exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_main(input string tag, input int ye, input int be,
                               input int de, input int re);
        check({tag, ".Y"}, int'(y), ye);
        check({tag, ".busy"}, int'(busy), be);
        check({tag, ".done"}, int'(done), de);
        check({tag, ".ready"}, int'(a_ready), re);
    endtask

    // One full default strobe from the accept cycle (c=0) to the next idle cycle.
    // Relative cycle c: Y on 1..4, done on 5, busy on 1..6, ready on 0 and 7.
    task automatic run_strobe(input string tag, input logic [2:0] code,
                              input logic hold_valid, input logic [2:0] a_after);
        a = code;
        a_valid = 1'b1;
        check({tag, ".accept_ready"}, int'(a_ready), 1);
        tick();
        a_valid = hold_valid;
        a = a_after;
        for (int c = 1; c <= 6; c++) begin
            expect_main($sformatf("%s.c%0d", tag, c),
                        (c <= 4) ? (1 << code) : 0,
                        (c <= 6) ? 1 : 0,
                        (c == 5) ? 1 : 0,
                        0);
            tick();
        end
        a = code;
        $display("strobe %s code=%0d done", tag, code);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        expect_main("reset", 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", int'(a_ready), 1);

        // Sweep codes 0..7
        for (int k = 0; k < 8; k++)
            run_strobe($sformatf("sweep%0d", k), 3'(k), 1'b0, 3'(k));
        check("sweep_idle_ready", int'(a_ready), 1);

        // Continuous valid with A=5: one strobe every 7 cycles
        run_strobe("hold1", 3'd5, 1'b1, 3'd5);
        run_strobe("hold2", 3'd5, 1'b1, 3'd5);
        a_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        check("hold_end_y", int'(y), 0);
        check("hold_end_ready", int'(a_ready), 1);

        // A changes during PULSE are ignored
        run_strobe("achg", 3'd3, 1'b0, 3'd6);

        // Abort in 2nd PULSE cycle of code 2
        a = 3'd2;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        expect_main("abort.c1", 8'h04, 1, 0, 0);
        tick();
        check("abort.c2_y", int'(y), 8'h04);
        en = 1'b0;
        tick();
        expect_main("abort.after", 0, 0, 0, 0);
        tick();
        expect_main("abort.after2", 0, 0, 0, 0);
        en = 1'b1;
        #1;
        check("abort.ready_again", int'(a_ready), 1);
        run_strobe("post_abort", 3'd1, 1'b0, 3'd1);

        // Reset mid-PULSE with Y = 0x10
        a = 3'd4;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        check("rstmid.y_before", int'(y), 8'h10);
        rst = 1'b1;
        tick();
        expect_main("rstmid.after", 0, 0, 0, 0);
        tick();
        check("rstmid.done_later", int'(done), 0);
        rst = 1'b0;
        #1;
        check("rstmid.ready_release", int'(a_ready), 1);

        // PULSE_LEN=1, GAP_LEN=0: codes 7 then 0 back to back
        s_a = 3'd7;
        s_valid = 1'b1;
        check("short.ready0", int'(s_ready), 1);
        tick();
        s_a = 3'd0;
        check("short.y80", int'(s_y), 8'h80);
        check("short.busy1", int'(s_busy), 1);
        check("short.ready_pulse", int'(s_ready), 0);
        tick();
        check("short.y00", int'(s_y), 0);
        check("short.done", int'(s_done), 1);
        check("short.busy_idle", int'(s_busy), 0);
        check("short.ready_idle", int'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        check("short.y01", int'(s_y), 8'h01);
        check("short.done_clr", int'(s_done), 0);
        $display("short back-to-back 7,0 done");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
